// File: rtl/braille_access_pkg.sv
// Shared definitions for the access sequencer: digit width, the controller
// state encoding (also driven out on state_o) and a small helper used to
// size the shared cycle timer.
package braille_access_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ID_ENTRY = 3'd1,
        ST_PW_ENTRY = 3'd2,
        ST_CHECK    = 3'd3,
        ST_GRANT    = 3'd4,
        ST_DENY     = 3'd5,
        ST_LOCKOUT  = 3'd6
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/access_sequencer_if.sv
// Keypad/status bundle of the access sequencer.
//   master: keypad side (drives loads, digits, pound_n, credentials)
//   slave : sequencer side (drives allow/deny/locked, state_o, counts,
//           last_digit)
// cred_id/cred_pw hold the stored credentials, first digit in the MSBs.
interface access_sequencer_if
    import braille_access_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                        id_load;
    logic [DIGIT_W-1:0]          id_digit;
    logic                        pw_load;
    logic [DIGIT_W-1:0]          pw_digit;
    logic                        pound_n;
    logic [DIGIT_W*DIGITS-1:0]   cred_id;
    logic [DIGIT_W*DIGITS-1:0]   cred_pw;
    logic                        allow;
    logic                        deny;
    logic                        locked;
    logic [2:0]                  state_o;
    logic [2:0]                  id_cnt;
    logic [2:0]                  pw_cnt;
    logic [DIGIT_W-1:0]          last_digit;

    modport master (
        output id_load, id_digit, pw_load, pw_digit, pound_n, cred_id, cred_pw,
        input  allow, deny, locked, state_o, id_cnt, pw_cnt, last_digit
    );

    modport slave (
        input  id_load, id_digit, pw_load, pw_digit, pound_n, cred_id, cred_pw,
        output allow, deny, locked, state_o, id_cnt, pw_cnt, last_digit
    );
endinterface

// File: rtl/key_edge.sv
// Registered edge detector for a keypad level.
//   clk, rst : clock, async active-high reset
//   lvl_i    : raw level
//   ev_o     : one-cycle registered pulse, one cycle after the level is
//              first sampled in its active state (rising edge, or falling
//              edge when FALL=1). A held level yields a single pulse.
// IDLE_LVL is the history value after reset, so a level already resting
// in its inactive state produces no spurious event.
module key_edge #(
    parameter bit FALL     = 1'b0,
    parameter bit IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic ev_o
);
    logic prev_q;
    logic ev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= IDLE_LVL;
            ev_q   <= 1'b0;
        end else begin
            prev_q <= lvl_i;
            ev_q   <= FALL ? (prev_q & ~lvl_i) : (~prev_q & lvl_i);
        end
    end

    assign ev_o = ev_q;
endmodule

// File: rtl/access_sequencer.sv
// Keypad access controller: collects DIGITS ID digits then DIGITS password
// digits, checks them on pound, shows allow/deny for SHOW_CYC cycles.
//   clk, rst : clock, async active-high reset
//   bus      : access_sequencer_if.slave (keypad inputs, credentials,
//              allow/deny/locked, state_o, id_cnt/pw_cnt, last_digit)
// Optional feature macro ACCESS_LOCKOUT_EN: MAX_FAIL consecutive denials
// lock the keypad for LOCK_CYC cycles. Without it DENY always returns to
// IDLE and locked is tied low.
module access_sequencer
    import braille_access_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int SHOW_CYC    = 50,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYC    = 5000
) (
    input  logic                clk,
    input  logic                rst,
    access_sequencer_if.slave   bus
);
    localparam int BW = DIGIT_W * DIGITS;
`ifdef ACCESS_LOCKOUT_EN
    localparam int TMAX = max_int(max_int(TIMEOUT_CYC, SHOW_CYC), LOCK_CYC);
    localparam int FW   = $clog2(MAX_FAIL + 1);
`else
    localparam int TMAX = max_int(TIMEOUT_CYC, SHOW_CYC);
`endif
    localparam int TW = $clog2(TMAX + 1);

    logic id_ev, pw_ev, pound_ev;

    key_edge #(.FALL(1'b0), .IDLE_LVL(1'b0)) u_id_edge (
        .clk(clk), .rst(rst), .lvl_i(bus.id_load), .ev_o(id_ev));
    key_edge #(.FALL(1'b0), .IDLE_LVL(1'b0)) u_pw_edge (
        .clk(clk), .rst(rst), .lvl_i(bus.pw_load), .ev_o(pw_ev));
    key_edge #(.FALL(1'b1), .IDLE_LVL(1'b1)) u_pound_edge (
        .clk(clk), .rst(rst), .lvl_i(bus.pound_n), .ev_o(pound_ev));

    state_e             state_q;
    logic [BW-1:0]      id_buf_q, pw_buf_q;
    logic [2:0]         id_cnt_q, pw_cnt_q;
    logic [DIGIT_W-1:0] last_q;
    // Digits are sampled alongside the load level so they line up with the
    // one-cycle-late event pulse.
    logic [DIGIT_W-1:0] id_dq_q, pw_dq_q;
    logic [TW-1:0]      timer_q;
    logic               allow_q, deny_q;
`ifdef ACCESS_LOCKOUT_EN
    logic [FW-1:0]      fail_q;
    logic               locked_q;
`else
    logic               unused_cfg;
    assign unused_cfg = (MAX_FAIL > 0) ^ (LOCK_CYC > 0);
`endif

    logic match;
    assign match = (id_cnt_q == 3'(DIGITS)) && (pw_cnt_q == 3'(DIGITS)) &&
                   (id_buf_q == bus.cred_id) && (pw_buf_q == bus.cred_pw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            id_buf_q <= '0;
            pw_buf_q <= '0;
            id_cnt_q <= '0;
            pw_cnt_q <= '0;
            last_q   <= '0;
            id_dq_q  <= '0;
            pw_dq_q  <= '0;
            timer_q  <= '0;
            allow_q  <= 1'b0;
            deny_q   <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
            fail_q   <= '0;
            locked_q <= 1'b0;
`endif
        end else begin
            id_dq_q <= bus.id_digit;
            pw_dq_q <= bus.pw_digit;
            case (state_q)
                ST_IDLE: begin
                    if (id_ev) begin
                        id_buf_q <= {id_buf_q[BW-DIGIT_W-1:0], id_dq_q};
                        id_cnt_q <= 3'd1;
                        last_q   <= id_dq_q;
                        timer_q  <= '0;
                        state_q  <= ST_ID_ENTRY;
                    end
                end
                ST_ID_ENTRY: begin
                    if (id_ev) begin
                        id_buf_q <= {id_buf_q[BW-DIGIT_W-1:0], id_dq_q};
                        id_cnt_q <= id_cnt_q + 3'd1;
                        last_q   <= id_dq_q;
                        timer_q  <= '0;
                        if (id_cnt_q == 3'(DIGITS - 1)) state_q <= ST_PW_ENTRY;
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        id_buf_q <= '0;
                        pw_buf_q <= '0;
                        id_cnt_q <= '0;
                        pw_cnt_q <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_PW_ENTRY: begin
                    // Any password key restarts the idle timer, even one
                    // dropped because the buffer is already full.
                    if (pw_ev) begin
                        timer_q <= '0;
                        if (pw_cnt_q != 3'(DIGITS)) begin
                            pw_buf_q <= {pw_buf_q[BW-DIGIT_W-1:0], pw_dq_q};
                            pw_cnt_q <= pw_cnt_q + 3'd1;
                            last_q   <= pw_dq_q;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                    if (pound_ev) begin
                        state_q <= ST_CHECK;
                    end else if (!pw_ev && timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        id_buf_q <= '0;
                        pw_buf_q <= '0;
                        id_cnt_q <= '0;
                        pw_cnt_q <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    timer_q <= '0;
                    if (match) begin
                        allow_q <= 1'b1;
                        state_q <= ST_GRANT;
                    end else begin
                        deny_q  <= 1'b1;
                        state_q <= ST_DENY;
`ifdef ACCESS_LOCKOUT_EN
                        if (fail_q != FW'(MAX_FAIL)) fail_q <= fail_q + FW'(1);
`endif
                    end
                end
                ST_GRANT: begin
                    if (timer_q == TW'(SHOW_CYC - 1)) begin
                        allow_q  <= 1'b0;
                        id_buf_q <= '0;
                        pw_buf_q <= '0;
                        id_cnt_q <= '0;
                        pw_cnt_q <= '0;
                        state_q  <= ST_IDLE;
`ifdef ACCESS_LOCKOUT_EN
                        fail_q   <= '0;
`endif
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_DENY: begin
                    if (timer_q == TW'(SHOW_CYC - 1)) begin
                        deny_q   <= 1'b0;
                        id_buf_q <= '0;
                        pw_buf_q <= '0;
                        id_cnt_q <= '0;
                        pw_cnt_q <= '0;
                        timer_q  <= '0;
                        state_q  <= ST_IDLE;
`ifdef ACCESS_LOCKOUT_EN
                        if (fail_q == FW'(MAX_FAIL)) begin
                            locked_q <= 1'b1;
                            state_q  <= ST_LOCKOUT;
                        end
`endif
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`ifdef ACCESS_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (timer_q == TW'(LOCK_CYC - 1)) begin
                        locked_q <= 1'b0;
                        fail_q   <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.allow      = allow_q;
    assign bus.deny       = deny_q;
`ifdef ACCESS_LOCKOUT_EN
    assign bus.locked     = locked_q;
`else
    assign bus.locked     = 1'b0;
`endif
    assign bus.state_o    = state_q;
    assign bus.id_cnt     = id_cnt_q;
    assign bus.pw_cnt     = pw_cnt_q;
    assign bus.last_digit = last_q;
endmodule

// File: tb/tb_access_sequencer.sv
// Directed bench for access_sequencer with default parameters. Inputs are
// driven 1 ns after the rising edge and outputs checked at that point.
module tb_access_sequencer;
    import braille_access_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    access_sequencer_if #(.DIGITS(4)) bus ();

    access_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_id(input logic [3:0] d);
        bus.id_digit = d;
        bus.id_load  = 1'b1;
        tick(2);
        bus.id_load  = 1'b0;
        tick(2);
    endtask

    task automatic press_pw(input logic [3:0] d);
        bus.pw_digit = d;
        bus.pw_load  = 1'b1;
        tick(2);
        bus.pw_load  = 1'b0;
        tick(2);
    endtask

    task automatic enter_id(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) press_id(v[i*4 +: 4]);
    endtask

    task automatic enter_pw(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) press_pw(v[i*4 +: 4]);
    endtask

    // Ends two cycles after pound_n was first sampled low.
    task automatic do_pound();
        bus.pound_n = 1'b0;
        tick(3);
        bus.pound_n = 1'b1;
    endtask

    task automatic wait_show(input string tag, input logic a, input logic d);
        tick(49);
        chk({tag, "_hold_allow"}, 32'(bus.allow), 32'(a));
        chk({tag, "_hold_deny"},  32'(bus.deny),  32'(d));
        tick(1);
        chk({tag, "_end_allow"}, 32'(bus.allow), 32'd0);
        chk({tag, "_end_deny"},  32'(bus.deny),  32'd0);
    endtask

    task automatic deny_submit(input string tag);
        enter_id(16'hCCC3);
        enter_pw(16'hCCC2);
        do_pound();
        chk({tag, "_deny"}, 32'(bus.deny), 32'd1);
    endtask

    initial begin
        bus.id_load  = 1'b0;
        bus.id_digit = 4'h0;
        bus.pw_load  = 1'b0;
        bus.pw_digit = 4'h0;
        bus.pound_n  = 1'b1;
        bus.cred_id  = 16'hCCC3;
        bus.cred_pw  = 16'hCCC3;

        // Reset state
        tick(3);
        chk("rst_state",  32'(bus.state_o),    32'(ST_IDLE));
        chk("rst_allow",  32'(bus.allow),      32'd0);
        chk("rst_deny",   32'(bus.deny),       32'd0);
        chk("rst_locked", 32'(bus.locked),     32'd0);
        chk("rst_idcnt",  32'(bus.id_cnt),     32'd0);
        chk("rst_pwcnt",  32'(bus.pw_cnt),     32'd0);
        chk("rst_last",   32'(bus.last_digit), 32'd0);
        rst = 1'b0;
        tick(2);

        // First digit latency and held-level single event
        bus.id_digit = 4'hC;
        bus.id_load  = 1'b1;
        tick(1);
        chk("lat_idcnt_early", 32'(bus.id_cnt), 32'd0);
        tick(1);
        chk("lat_idcnt",  32'(bus.id_cnt),     32'd1);
        chk("lat_last",   32'(bus.last_digit), 32'hC);
        chk("lat_state",  32'(bus.state_o),    32'(ST_ID_ENTRY));
        tick(4);
        chk("held_idcnt", 32'(bus.id_cnt), 32'd1);
        bus.id_load = 1'b0;
        tick(2);
        press_id(4'hC);
        press_id(4'hC);
        press_id(4'h3);
        chk("id_full_state", 32'(bus.state_o), 32'(ST_PW_ENTRY));
        chk("id_full_cnt",   32'(bus.id_cnt),  32'd4);
        press_id(4'h5);
        chk("id_in_pw_cnt",  32'(bus.id_cnt),     32'd4);
        chk("id_in_pw_last", 32'(bus.last_digit), 32'h3);
        enter_pw(16'hCCC3);
        chk("pw_full_cnt", 32'(bus.pw_cnt), 32'd4);
        bus.pound_n = 1'b0;
        tick(1);
        chk("pound_a_allow", 32'(bus.allow),   32'd0);
        tick(1);
        chk("pound_b_state", 32'(bus.state_o), 32'(ST_CHECK));
        chk("pound_b_allow", 32'(bus.allow),   32'd0);
        tick(1);
        chk("grant_allow", 32'(bus.allow),   32'd1);
        chk("grant_state", 32'(bus.state_o), 32'(ST_GRANT));
        bus.pound_n = 1'b1;
        wait_show("grant", 1'b1, 1'b0);
        chk("grant_idle",  32'(bus.state_o), 32'(ST_IDLE));
        chk("grant_idcnt", 32'(bus.id_cnt),  32'd0);
        chk("grant_pwcnt", 32'(bus.pw_cnt),  32'd0);

        // Wrong last password digit
        enter_id(16'hCCC3);
        enter_pw(16'hCCC2);
        do_pound();
        chk("wrong_deny",  32'(bus.deny),  32'd1);
        chk("wrong_allow", 32'(bus.allow), 32'd0);
        wait_show("wrong", 1'b0, 1'b1);
        chk("wrong_idle", 32'(bus.state_o), 32'(ST_IDLE));

        // Short password
        enter_id(16'hCCC3);
        press_pw(4'hC);
        press_pw(4'hC);
        do_pound();
        chk("short_deny", 32'(bus.deny), 32'd1);
        wait_show("short", 1'b0, 1'b1);

        // Extra password digit dropped
        enter_id(16'hCCC3);
        enter_pw(16'hCCC3);
        press_pw(4'h7);
        chk("extra_pwcnt", 32'(bus.pw_cnt),     32'd4);
        chk("extra_last",  32'(bus.last_digit), 32'h3);
        do_pound();
        chk("extra_allow", 32'(bus.allow), 32'd1);
        wait_show("extra", 1'b1, 1'b0);

        // Final password digit and pound in the same cycle
        enter_id(16'hCCC3);
        press_pw(4'hC);
        press_pw(4'hC);
        press_pw(4'hC);
        bus.pw_digit = 4'h3;
        bus.pw_load  = 1'b1;
        bus.pound_n  = 1'b0;
        tick(2);
        chk("same_state", 32'(bus.state_o), 32'(ST_CHECK));
        chk("same_pwcnt", 32'(bus.pw_cnt),  32'd4);
        tick(1);
        chk("same_allow", 32'(bus.allow), 32'd1);
        bus.pw_load = 1'b0;
        bus.pound_n = 1'b1;
        wait_show("same", 1'b1, 1'b0);

        // Three consecutive denials
        deny_submit("d1");
        wait_show("d1", 1'b0, 1'b1);
        deny_submit("d2");
        wait_show("d2", 1'b0, 1'b1);
        deny_submit("d3");
        wait_show("d3", 1'b0, 1'b1);
`ifdef ACCESS_LOCKOUT_EN
        chk("lock_on",       32'(bus.locked),  32'd1);
        chk("lock_state",    32'(bus.state_o), 32'(ST_LOCKOUT));
        press_id(4'h5);
        chk("lock_ign_cnt",  32'(bus.id_cnt),  32'd0);
        chk("lock_ign_st",   32'(bus.state_o), 32'(ST_LOCKOUT));
        tick(4995);
        chk("lock_hold",     32'(bus.locked),  32'd1);
        tick(1);
        chk("lock_off",      32'(bus.locked),  32'd0);
        chk("lock_idle",     32'(bus.state_o), 32'(ST_IDLE));
`else
        chk("nolock_locked", 32'(bus.locked),  32'd0);
        chk("nolock_idle",   32'(bus.state_o), 32'(ST_IDLE));
`endif

        // Entry timeout leaves the fail count alone
        deny_submit("t1");
        wait_show("t1", 1'b0, 1'b1);
        deny_submit("t2");
        wait_show("t2", 1'b0, 1'b1);
        press_id(4'h7);
        tick(990);
        chk("to_before_state", 32'(bus.state_o), 32'(ST_ID_ENTRY));
        chk("to_before_cnt",   32'(bus.id_cnt),  32'd1);
        tick(10);
        chk("to_state", 32'(bus.state_o), 32'(ST_IDLE));
        chk("to_cnt",   32'(bus.id_cnt),  32'd0);
        deny_submit("t3");
`ifdef ACCESS_LOCKOUT_EN
        wait_show("t3", 1'b0, 1'b1);
        chk("to_fail_kept", 32'(bus.locked), 32'd1);
        tick(100);
        #2 rst = 1'b1;
        #1;
        chk("rst_lock_locked", 32'(bus.locked),  32'd0);
        chk("rst_lock_state",  32'(bus.state_o), 32'(ST_IDLE));
`else
        tick(10);
        #2 rst = 1'b1;
        #1;
        chk("rst_deny_deny",  32'(bus.deny),    32'd0);
        chk("rst_deny_state", 32'(bus.state_o), 32'(ST_IDLE));
`endif
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("post_rst_state", 32'(bus.state_o), 32'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/access_sequencer.md
ACCESS_SEQUENCER -- requirements
Module: access_sequencer

Interface
REQ-001 SHALL have parameter DIGITS, default 4: digits per ID and per password.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000: idle cycles allowed between digits before entry is abandoned.
REQ-003 SHALL have parameter SHOW_CYC, default 50: cycles allow/deny is held.
REQ-004 SHALL have parameter MAX_FAIL, default 3: consecutive denials that trigger lockout.
REQ-005 SHALL have parameter LOCK_CYC, default 5000: lockout duration in cycles.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port id_load, input, 1: level; each rising edge enters one ID digit.
REQ-009 SHALL have port id_digit, input, 4: ID digit value.
REQ-010 SHALL have port pw_load, input, 1: level; each rising edge enters one password digit.
REQ-011 SHALL have port pw_digit, input, 4: password digit value.
REQ-012 SHALL have port pound_n, input, 1: active-low submit; its falling edge is the event.
REQ-013 SHALL have port cred_id, input, 4*DIGITS: stored ID, first digit in the MSBs.
REQ-014 SHALL have port cred_pw, input, 4*DIGITS: stored password, first digit in the MSBs.
REQ-015 SHALL have ports allow, deny and locked, each output, 1: access status.
REQ-016 SHALL have port state_o, output, 3: current state encoding.
REQ-017 SHALL have ports id_cnt and pw_cnt, each output, 3: digits captured so far.
REQ-018 SHALL have port last_digit, output, 4: most recently captured digit, for seven-segment display.

Function
REQ-019 SHALL detect events with registered edge detectors; captured digit and count visible one cycle after load first sampled high; a held level gives one event only.
REQ-020 SHALL implement states IDLE, ID_ENTRY, PW_ENTRY, CHECK, GRANT, DENY, LOCKOUT.
REQ-021 IDLE: id_load event SHALL shift digit into ID buffer (MSB-first), set id_cnt=1, go to ID_ENTRY.
REQ-022 ID_ENTRY: id_load events SHALL shift and count; at id_cnt==DIGITS go to PW_ENTRY; pw_load and pound ignored.
REQ-023 PW_ENTRY: pw_load events SHALL shift and count; pw_cnt saturates at DIGITS and extra digits are dropped; pound event goes to CHECK whatever the count.
REQ-024 Same-cycle pw_load and pound events in PW_ENTRY: the digit SHALL be captured and included in CHECK.
REQ-025 Events not valid in the current state SHALL be ignored, including id_load during PW_ENTRY.
REQ-026 CHECK SHALL last 1 cycle: match = (id_cnt==DIGITS) and (pw_cnt==DIGITS) and buffers equal cred_id and cred_pw; match goes to GRANT, else DENY; allow/deny rise 2 cycles after pound_n first sampled low.
REQ-027 GRANT SHALL hold allow=1 for SHOW_CYC cycles, clear fail counter, clear buffers and counts, then go to IDLE.
REQ-028 DENY SHALL hold deny=1 for SHOW_CYC cycles and increment the fail counter (saturating), then go to LOCKOUT if fail==MAX_FAIL, else IDLE; buffers cleared.
REQ-029 LOCKOUT SHALL hold locked=1, ignore all inputs for LOCK_CYC cycles, clear fail, then go to IDLE.
REQ-030 ID_ENTRY/PW_ENTRY with no digit event for TIMEOUT_CYC cycles SHALL return to IDLE, clear buffers, leave fail unchanged.

Reset
REQ-031 rst SHALL force IDLE; allow, deny and locked to 0; counts, buffers, last_digit, fail and timers to 0; edge-detector history to inactive (pound_n history=1).
REQ-032 Reset in any state, including LOCKOUT, SHALL take effect immediately with no residual lockout.

Configuration
REQ-033 With ACCESS_LOCKOUT_EN defined, LOCKOUT and the fail counter SHALL exist per REQ-028/029; undefined, DENY SHALL always return to IDLE, locked SHALL be tied 0, and no fail counter or lock timer SHALL be built.

Structure
REQ-034 Package braille_access_pkg SHALL hold the state enum/encodings and DIGIT_W=4.
REQ-035 Sub-module key_edge (registered rise/fall detector) SHALL be instanced for id_load, pw_load and pound_n.

Verification
REQ-036 cred_id=cred_pw=16'hCCC3; ID C,C,C,3 then PW C,C,C,3, pound -> allow=1 for 50 cycles, state IDLE after.
REQ-037 Same ID, PW C,C,C,2 -> deny=1 for 50 cycles, fail=1.
REQ-038 Three wrong submissions -> locked=1 for 5000 cycles, id_load ignored, then IDLE (ACCESS_LOCKOUT_EN only).
REQ-039 ID full, PW 2 digits then pound -> deny; 5 PW digits then pound -> pw_cnt=4, allow.
REQ-040 One ID digit then 1000 idle cycles -> IDLE, id_cnt=0, fail unchanged.
REQ-041 Assert rst mid-LOCKOUT -> locked=0 and state IDLE without waiting for a clock edge.
